// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential execute ALU.
// Op encodings, FSM states and divider corner-case resolution.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SLL    = 5'b00001,
        OP_SLT    = 5'b00010,
        OP_SLTU   = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_OR     = 5'b00110,
        OP_AND    = 5'b00111,
        OP_SUB    = 5'b01000,
        OP_SRA    = 5'b01101,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } op_e;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    localparam int MAXW = 64;

    typedef struct packed {
        logic            special;
        logic [MAXW-1:0] q;
        logic [MAXW-1:0] r;
    } div_spec_t;

    // Operands arrive zero-extended to MAXW; xlen selects the live width.
    function automatic div_spec_t div_special(
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b,
        input logic            signed_op,
        input int unsigned     xlen
    );
        div_spec_t       s;
        logic [MAXW-1:0] mask;
        logic [MAXW-1:0] min_neg;
        mask    = (xlen >= MAXW) ? '1
                : ((MAXW'(1) << xlen) - MAXW'(1));
        min_neg = MAXW'(1) << (xlen - 1);
        s       = '0;
        if (b == '0) begin
            s.special = 1'b1;
            s.q       = mask;
            s.r       = a;
        end else if (signed_op && a == min_neg && b == mask) begin
            s.special = 1'b1;
            s.q       = a;
            s.r       = '0;
        end
        return s;
    endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle; done flags the cycle of the final step.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            ge;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dsr_q};
        ge      = ~trial[XLEN];
        quo_d   = {quo_q[XLEN-2:0], ge};
        rem_d   = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end

    // Outputs expose the post-step values so the caller can latch them
    // on the same edge that retires the last step.
    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CW'(XLEN - 1));
    assign quotient  = quo_d;
    assign remainder = rem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (flush) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dsr_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: base ops, branch compare and RV M-extension
// behind valid/ready handshakes on both sides.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch
);

    localparam int SW = $clog2(XLEN);
    localparam int PW = 2 * XLEN;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            br_q, br_d;
    logic            hi_q, hi_d;
    logic            rsel_q, rsel_d;
    logic            nq_q, nq_d;
    logic            nr_q, nr_d;

    logic            accept;
    logic            eq, lt_s, lt_u;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] base_res;
    logic            base_br;

    logic            sa, sb;
    logic [PW+1:0]   ma, mb, mprod;
    logic [PW-1:0]   mfull;

    logic            d_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    div_spec_t       sp;
    logic            div_start;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_quo, div_rem;
    logic            unused_ok;

    assign in_ready  = rst_n
                     && (state_q == IDLE
                     || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign branch    = br_q;

    assign eq    = (operand_a == operand_b);
    assign lt_s  = $signed(operand_a) < $signed(operand_b);
    assign lt_u  = operand_a < operand_b;
    assign shamt = operand_b[SW-1:0];

    always_comb begin
        base_res = '0;
        case (op_e'({1'b0, op[3:0]}))
            OP_ADD:  base_res = operand_a + operand_b;
            OP_SUB:  base_res = operand_a - operand_b;
            OP_XOR:  base_res = operand_a ^ operand_b;
            OP_OR:   base_res = operand_a | operand_b;
            OP_AND:  base_res = operand_a & operand_b;
            OP_SLL:  base_res = operand_a << shamt;
            OP_SRL:  base_res = operand_a >> shamt;
            OP_SRA:  base_res = $signed(operand_a) >>> shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, lt_u};
            default: base_res = '0;
        endcase
    end

    always_comb begin
        base_br = 1'b0;
        case (op[2:0])
            BR_EQ:   base_br = eq;
            BR_NE:   base_br = ~eq;
            BR_LT:   base_br = lt_s;
            BR_GE:   base_br = ~lt_s;
            BR_LTU:  base_br = lt_u;
            BR_GEU:  base_br = ~lt_u;
            default: base_br = 1'b0;
        endcase
    end

    // One widened unsigned multiply covers all signedness mixes.
    assign sa    = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
    assign sb    = (op[1:0] == 2'b01);
    assign ma    = {{(XLEN+2){sa & operand_a[XLEN-1]}}, operand_a};
    assign mb    = {{(XLEN+2){sb & operand_b[XLEN-1]}}, operand_b};
    assign mprod = ma * mb;
    assign mfull = mprod[PW-1:0];

    assign d_signed = ~op[0];
    assign a_neg    = d_signed & operand_a[XLEN-1];
    assign b_neg    = d_signed & operand_b[XLEN-1];
    assign a_mag    = a_neg ? -operand_a : operand_a;
    assign b_mag    = b_neg ? -operand_b : operand_b;
    assign sp       = div_special(MAXW'(operand_a), MAXW'(operand_b),
                                  d_signed, XLEN);

    div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    assign unused_ok = ^{sp, mprod, div_busy};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        res_d     = res_q;
        br_d      = br_q;
        hi_d      = hi_q;
        rsel_d    = rsel_q;
        nq_d      = nq_q;
        nr_d      = nr_q;
        div_start = 1'b0;

        case (state_q)
            MUL: begin
                if (cnt_q == 2'd1) begin
                    state_d = DONE;
                    res_d   = hi_q ? prod_q[PW-1:XLEN]
                                   : prod_q[XLEN-1:0];
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = DONE;
                    if (rsel_q) begin
                        res_d = nr_q ? -div_rem : div_rem;
                    end else begin
                        res_d = nq_q ? -div_quo : div_quo;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accepting in DONE overrides the return to IDLE.
        if (accept) begin
            br_d = 1'b0;
            if (!op[4]) begin
                state_d = DONE;
                res_d   = base_res;
                br_d    = base_br;
            end else if (!op[2]) begin
                hi_d   = |op[1:0];
                prod_d = mfull;
                if (MUL_LAT == 1) begin
                    state_d = DONE;
                    res_d   = hi_d ? mfull[PW-1:XLEN]
                                   : mfull[XLEN-1:0];
                end else begin
                    state_d = MUL;
                    cnt_d   = 2'(MUL_LAT - 1);
                end
            end else if (sp.special) begin
                state_d = DONE;
                res_d   = op[1] ? sp.r[XLEN-1:0] : sp.q[XLEN-1:0];
            end else begin
                state_d   = DIV;
                div_start = 1'b1;
                rsel_d    = op[1];
                nq_d      = a_neg ^ b_neg;
                nr_d      = a_neg;
            end
        end

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            hi_q    <= 1'b0;
            rsel_q  <= 1'b0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            br_q    <= br_d;
            hi_q    <= hi_d;
            rsel_q  <= rsel_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (XLEN=32, MUL_LAT=2).
// Inputs change on negedge; outputs are sampled on negedge.
module tb_alu_seq;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = XLEN + 1;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            branch;

    int total;
    int bad;

    alu_seq #(
        .XLEN   (XLEN),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .branch   (branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op with out_ready high; lat counts edges from accept
    // to the first negedge showing out_valid (100 means timed out).
    task automatic run_op(input logic [4:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output int lat,
                          output logic [31:0] res,
                          output logic br);
        @(negedge clk);
        op        = o;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        br  = branch;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || result !== 32'h0
            || branch !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: v=%b r=%h b=%b rdy=%b want 0 0 0 0",
                     out_valid, result, branch, in_ready);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: rdy=%b v=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_base;
        logic [4:0]  vo [11] = '{5'b00000, 5'b01101, 5'b00101, 5'b01000,
                                 5'b00010, 5'b00011, 5'b00100, 5'b00111,
                                 5'b00110, 5'b00000, 5'b01001};
        logic [31:0] va [11] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                                 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'd3, 32'd1};
        logic [31:0] vb [11] = '{32'd1, 32'd4, 32'd1, 32'd7, 32'd1, 32'd1,
                                 32'hFF00FF00, 32'hFF00FF00, 32'h0F0F0F0F,
                                 32'd3, 32'd2};
        logic [31:0] vr [11] = '{32'h80000000, 32'hF8000000, 32'h7FFFFFFF,
                                 32'hFFFFFFFE, 32'd1, 32'd0, 32'h0FF00FF0,
                                 32'hF000F000, 32'hFFFFFFFF, 32'd6, 32'd0};
        logic        vbr [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          lat;
        logic [31:0] res;
        logic        br;
        for (int i = 0; i < 11; i++) begin
            run_op(vo[i], va[i], vb[i], lat, res, br);
            total++;
            if (lat !== 1) begin
                bad++;
                $display("FAIL base_lat[%0d]: got %0d want 1", i, lat);
            end
            total++;
            if (res !== vr[i] || br !== vbr[i]) begin
                bad++;
                $display("FAIL base[%0d]: res=%h br=%b want %h %b",
                         i, res, br, vr[i], vbr[i]);
            end
        end
    endtask

    task automatic test_mul;
        logic [4:0]  vo [5] = '{5'b10001, 5'b10011, 5'b10010,
                                5'b10000, 5'b11000};
        logic [31:0] va [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h12345678, 32'd7};
        logic [31:0] vb [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                32'h10, 32'd6};
        logic [31:0] vr [5] = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                32'h23456780, 32'd42};
        int          lat;
        logic [31:0] res;
        logic        br;
        // Leave branch=1 behind so an M op must actively clear it.
        run_op(5'b00000, 32'd3, 32'd3, lat, res, br);
        for (int i = 0; i < 5; i++) begin
            run_op(vo[i], va[i], vb[i], lat, res, br);
            total++;
            if (lat !== MUL_LAT) begin
                bad++;
                $display("FAIL mul_lat[%0d]: got %0d want %0d",
                         i, lat, MUL_LAT);
            end
            total++;
            if (res !== vr[i] || br !== 1'b0) begin
                bad++;
                $display("FAIL mul[%0d]: res=%h br=%b want %h 0",
                         i, res, br, vr[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [4:0]  vo [11] = '{5'b10100, 5'b10110, 5'b10101, 5'b10111,
                                 5'b10100, 5'b10110, 5'b10101, 5'b10111,
                                 5'b10110, 5'b10100, 5'b10100};
        logic [31:0] va [11] = '{32'hFFFFFF9C, 32'hFFFFFF9C, 32'd100, 32'd100,
                                 32'd100, 32'd100, 32'h80000000, 32'h80000000,
                                 32'd5, 32'h80000000, 32'd5};
        logic [31:0] vb [11] = '{32'd7, 32'd7, 32'd7, 32'd7,
                                 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0};
        logic [31:0] vr [11] = '{32'hFFFFFFF2, 32'hFFFFFFFE, 32'd14, 32'd2,
                                 32'hFFFFFFF2, 32'd2, 32'd0, 32'h80000000,
                                 32'd5, 32'h80000000, 32'hFFFFFFFF};
        int          vl [11] = '{DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT,
                                 DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT,
                                 1, 1, 1};
        int          lat;
        logic [31:0] res;
        logic        br;
        for (int i = 0; i < 11; i++) begin
            run_op(vo[i], va[i], vb[i], lat, res, br);
            total++;
            if (lat !== vl[i]) begin
                bad++;
                $display("FAIL div_lat[%0d]: got %0d want %0d",
                         i, lat, vl[i]);
            end
            total++;
            if (res !== vr[i] || br !== 1'b0) begin
                bad++;
                $display("FAIL div[%0d]: res=%h br=%b want %h 0",
                         i, res, br, vr[i]);
            end
        end
    endtask

    task automatic test_special;
        logic [4:0]  vo [4] = '{5'b10101, 5'b10110, 5'b10100, 5'b10110};
        logic [31:0] va [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] vb [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vr [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int          lat;
        logic [31:0] res;
        logic        br;
        for (int i = 0; i < 4; i++) begin
            run_op(vo[i], va[i], vb[i], lat, res, br);
            total++;
            if (lat !== 1 || res !== vr[i]) begin
                bad++;
                $display("FAIL special[%0d]: lat=%0d res=%h want 1 %h",
                         i, lat, res, vr[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        op        = 5'b00001;
        operand_a = 32'd1;
        operand_b = 32'd4;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== 32'd16
                || branch !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall[%0d]: v=%b r=%h b=%b rdy=%b want 1 10 1 0",
                         i, out_valid, result, branch, in_ready);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 5'b00000;
        operand_a = 32'd2;
        operand_b = 32'd3;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || result !== 32'd5 || branch !== 1'b0) begin
            bad++;
            $display("FAIL b2b_next: v=%b r=%h b=%b want 1 5 0",
                     out_valid, result, branch);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush;
        int          lat;
        logic [31:0] res;
        logic        br;
        logic        seen;
        @(negedge clk);
        op        = 5'b10101;
        operand_a = 32'd100;
        operand_b = 32'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush     = 1'b1;
        in_valid  = 1'b1;
        op        = 5'b00000;
        operand_a = 32'd1;
        operand_b = 32'd1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_div: rdy=%b v=%b want 1 0",
                     in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL flush_stale: out_valid seen=%b want 0", seen);
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        op        = 5'b00000;
        operand_a = 32'd9;
        operand_b = 32'd9;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_drop: v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
        run_op(5'b00000, 32'd20, 32'd22, lat, res, br);
        total++;
        if (lat !== 1 || res !== 32'd42) begin
            bad++;
            $display("FAIL flush_after: lat=%0d res=%h want 1 2a", lat, res);
        end
    endtask

    task automatic test_reset_mid_mul;
        int          lat;
        logic [31:0] res;
        logic        br;
        run_op(5'b00000, 32'd40, 32'd2, lat, res, br);
        @(negedge clk);
        op        = 5'b10000;
        operand_a = 32'd9;
        operand_b = 32'd9;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if (result !== 32'd42 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_mul_pre: r=%h v=%b want 2a 0",
                     result, out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'h0
            || branch !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_mul_rst: v=%b r=%h b=%b rdy=%b want 0 0 0 0",
                     out_valid, result, branch, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_mul_after: v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
        run_op(5'b10000, 32'd7, 32'd6, lat, res, br);
        total++;
        if (lat !== MUL_LAT || res !== 32'd42) begin
            bad++;
            $display("FAIL mid_mul_redo: lat=%0d res=%h want %0d 2a",
                     lat, res, MUL_LAT);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        operand_a = '0;
        operand_b = '0;
        test_reset;
        test_base;
        test_mul;
        test_div;
        test_special;
        test_back_to_back;
        test_flush;
        test_reset_mid_mul;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle successor to the combinational execute ALU, parametrised in datapath width XLEN.
- Adds the RV32M/RV64M multiply/divide ops to the existing base ops, behind a valid/ready handshake on input and output.
- Base ops and branch compare complete in 1 cycle; multiply takes MUL_LAT cycles; divide/remainder uses an iterative radix-2 core.
- Sits in the EX stage; the pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- MUL_LAT, 2, cycles from multiply accept to out_valid; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kills any accepted or in-flight op.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept this cycle.
- op  in  5  operation code; see Behaviour.
- operand_a  in  XLEN  rs1 value.
- operand_b  in  XLEN  rs2 or immediate.
- out_valid  out  1  result/branch valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  computed value.
- branch  out  1  branch-taken flag; 0 for M ops.

Behaviour:
- Reset: async on rst_n low. State IDLE; in_ready=1 once out of reset; out_valid=0, result=0, branch=0; divider and counters cleared.
- Op encoding, op[4]=0 (base; op[3:0] as the existing ALU):
  - add 0000, sub 1000, xor 0100, or 0110, and 0111.
  - sll 0001, srl 0101, sra 1101 (shamt = operand_b[log2(XLEN)-1:0]).
  - slt 0010, sltu 0011; all other codes give result 0.
  - branch from op[2:0]: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 give 0.
- Op encoding, op[4]=1 (M ops; op[2:0]): mul 000, mulh 001, mulhsu 010, mulhu 011, div 100, divu 101, rem 110, remu 111; op[3] ignored.
- Accept: in_valid && in_ready at the rising edge (cycle T); operands and op are registered at T.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: base op -> DONE. mul* -> MUL, counter=MUL_LAT-1 (MUL_LAT=1 goes straight to DONE). div* with divisor 0 or signed overflow -> DONE. Other div* -> DIV.
  - MUL: counter decrements each cycle; at 0 go to DONE with the product slice. mul = low XLEN bits; mulh/mulhsu/mulhu = high XLEN bits of the 2*XLEN product, with signed x signed / signed x unsigned / unsigned x unsigned operands respectively.
  - DIV: one restoring step per cycle for XLEN cycles, operating on magnitudes; the sign fix applied when entering DONE. Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - DONE: out_valid=1; result and branch held stable until out_ready. On out_valid && out_ready go to IDLE, or if in_valid accept the next op in the same cycle.
- Latency (accept at T to first out_valid): base ops T+1; mul* T+MUL_LAT; div* T+XLEN+1; special-case div* T+1.
- Special cases:
  - Divide by zero: div/divu quotient = all ones; rem/remu = operand_a.
  - Signed overflow (a = -2^(XLEN-1), b = -1, div/rem): quotient = operand_a, remainder = 0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). No combinational path from in_valid to out_valid.
- flush has priority over every other event: FSM goes to IDLE, out_valid=0 next cycle, any op at in_valid in that cycle is dropped, in_ready=1 next cycle.
- Reset mid-op: aborts immediately; no stale out_valid after rst_n releases.
- Arithmetic wraps modulo 2^XLEN; no overflow flags.

Decomposition:
- alu_pkg holds:
  - the op_e enum for the 5-bit encodings;
  - the branch code localparams;
  - the state_e enum {IDLE, MUL, DIV, DONE};
  - a function div_special(a, b, signed_op) returning {is_special, quotient, remainder}.
- Sub-module div_iter (parameter XLEN): start, dividend/divisor magnitudes, busy, done, quotient, remainder. Cleared by rst_n and flush.
- Multiplier: a single registered 2*XLEN product held for MUL_LAT cycles, inline in alu_seq.

Test Plan:
- Base op and branch: add 0x7FFFFFFF+1 -> out_valid at T+1, result 0x80000000. sra 0x80000000 by 4 -> 0xF8000000. bge op 00101 with a=-1, b=1 -> branch=0.
- Multiply: mulh 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; mulhu same operands -> 0xFFFFFFFE; mulhsu -1 x 2 -> 0xFFFFFFFF; each at T+MUL_LAT.
- Divide: div -100/7 -> quotient -14 (0xFFFFFFF2) and rem -100,7 -> -2 (0xFFFFFFFE), out_valid at T+33; divu 100/7 -> 14; remu 100,7 -> 2.
- Special cases: divu 5/0 -> 0xFFFFFFFF at T+1; rem 5,0 -> 5; div 0x80000000/-1 -> 0x80000000; rem same operands -> 0.
- Backpressure and back-to-back: out_ready=0 for 5 cycles -> result and branch stable, in_ready=0. Raise out_ready with in_valid high -> next op accepted in the same cycle, its out_valid the next cycle.
- Abort: flush at T+10 of a div -> out_valid never asserts, in_ready=1 at T+11, a new add returns its correct result. rst_n low mid-mul -> all outputs 0 immediately.
